// File: rtl/icache_2way_if.sv
// Fetch/refill bundle for icache_2way: fetch request/response plus the serial nibble refill stream.
// Optional ICACHE_STATS_EN adds hit/miss counters to the bundle.
interface icache_2way_if #(
  parameter int PA          = 22,
  parameter int RV          = 16,
  parameter int LINE_LENGTH = 8
);
  localparam int OFFW = $clog2(LINE_LENGTH);

  logic              req;
  logic [PA-1:1]     paddr;
  logic              invalidate;
  logic [3:0]        dread;
  logic              wstrobe_d;
  logic              hit;
  logic              pull;
  logic [PA-1:OFFW]  tag;
  logic [RV-1:0]     rdata;
`ifdef ICACHE_STATS_EN
  logic [15:0]       hit_count;
  logic [15:0]       miss_count;
`endif

  modport slave (
    input  req, paddr, invalidate, dread, wstrobe_d,
`ifdef ICACHE_STATS_EN
    output hit_count, miss_count,
`endif
    output hit, pull, tag, rdata
  );

  modport master (
    output req, paddr, invalidate, dread, wstrobe_d,
`ifdef ICACHE_STATS_EN
    input  hit_count, miss_count,
`endif
    input  hit, pull, tag, rdata
  );
endinterface

// File: rtl/icache_2way.sv
// 2-way set-associative I-cache, zero-latency lookup, LRU victim, serial nibble refill FSM.
// ICACHE_STATS_EN adds saturating hit/miss counters cleared by reset or invalidate.
module icache_2way #(
  parameter int LINE_LENGTH = 8,
  parameter int NSETS       = 4,
  parameter int RV          = 16,
  parameter int PA          = 22
) (
  input  logic          clk,
  input  logic          reset,
  icache_2way_if.slave  bus
);
  localparam int OFFW  = $clog2(LINE_LENGTH);
  localparam int IDXW  = $clog2(NSETS);
  localparam int WSELW = $clog2(RV/8);
  localparam int TAGW  = PA - OFFW - IDXW;
  localparam int LADW  = PA - OFFW;
  localparam int LBITS = LINE_LENGTH * 8;
  localparam int NNIB  = LINE_LENGTH * 2;
  localparam int CNTW  = $clog2(NNIB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [LBITS-1:0] data_q  [NSETS][2];
  logic [TAGW-1:0]  tag_q   [NSETS][2];
  logic [1:0]       valid_q [NSETS];
  logic [NSETS-1:0] lru_q;

  logic [1:0]       state_q, state_d;
  logic [CNTW-1:0]  cnt_q;
  logic [LADW-1:0]  fline_q;
  logic             victim_q;
  logic             abort_q;

  logic [PA-1:0]    addr;
  logic [IDXW-1:0]  idx;
  logic [TAGW-1:0]  ptag;
  logic [OFFW-1:0]  wsel;
  logic [IDXW-1:0]  fidx;
  logic [TAGW-1:0]  ftag;
  logic             hit0, hit1, hit, hway, vict;
  logic             last, miss_start, fill_wr, fill_done;

  assign addr = {bus.paddr, 1'b0};
  assign idx  = addr[OFFW+IDXW-1:OFFW];
  assign ptag = addr[PA-1:OFFW+IDXW];
  assign wsel = addr[OFFW-1:0] >> WSELW;
  assign fidx = fline_q[IDXW-1:0];
  assign ftag = fline_q[LADW-1:IDXW];

  // Way 0 takes priority should both ways ever match.
  assign hit0 = valid_q[idx][0] && (tag_q[idx][0] == ptag);
  assign hit1 = valid_q[idx][1] && (tag_q[idx][1] == ptag);
  assign hway = ~hit0;
  assign hit  = bus.req && (state_q == S_IDLE) && (hit0 || hit1);
  assign vict = !valid_q[idx][0] ? 1'b0 : (!valid_q[idx][1] ? 1'b1 : lru_q[idx]);

  assign last       = (cnt_q == CNTW'(NNIB - 1));
  assign miss_start = (state_q == S_IDLE) && bus.req && !hit;
  assign fill_wr    = (state_q == S_FILL) && bus.wstrobe_d;
  assign fill_done  = fill_wr && last;

  assign bus.hit   = hit;
  assign bus.pull  = (state_q == S_FILL);
  assign bus.tag   = fline_q;
  assign bus.rdata = data_q[idx][hway][wsel*RV +: RV];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (miss_start) state_d = S_FILL;
      S_FILL:  if (fill_done)  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      fline_q  <= '0;
      victim_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (miss_start) begin
          fline_q  <= {ptag, idx};
          victim_q <= vict;
          cnt_q    <= '0;
        end
        S_FILL: begin
          if (bus.wstrobe_d)  cnt_q   <= cnt_q + 1'b1;
          if (bus.invalidate) abort_q <= 1'b1;
        end
        default: abort_q <= 1'b0;
      endcase
    end
  end

  // Invalidate outranks a completing fill, so a line finishing that cycle stays invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NSETS; s++) valid_q[s] <= '0;
      lru_q <= '0;
    end else if (bus.invalidate) begin
      for (int s = 0; s < NSETS; s++) valid_q[s] <= '0;
      lru_q <= '0;
    end else begin
      if (hit) lru_q[idx] <= ~hway;
      if (fill_done) begin
        valid_q[fidx][victim_q] <= ~abort_q;
        lru_q[fidx]             <= ~victim_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_wr) begin
      data_q[fidx][victim_q][cnt_q*4 +: 4] <= bus.dread;
      if (last) tag_q[fidx][victim_q] <= ftag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (bus.invalidate) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && hit_cnt_q != 16'hFFFF)         hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (miss_start && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_2way.sv
// Scoreboard bench for icache_2way: expected rdata queued per hitting request, popped when hit is seen.
module tb_icache_2way;
  localparam int PA = 22;
  localparam int RV = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [RV-1:0] exp_q[$];

  always #5 clk = ~clk;

  icache_2way_if #(.PA(PA), .RV(RV), .LINE_LENGTH(8)) bus ();

  icache_2way #(.LINE_LENGTH(8), .NSETS(4), .RV(RV), .PA(PA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Memory image: nibble n of line L.
  function automatic logic [3:0] nib(input int l, input int n);
    return 4'((n + 3 * (l - 2)) & 15);
  endfunction

  function automatic logic [RV-1:0] exp_word(input int a);
    logic [RV-1:0] r;
    int l, w;
    l = a >> 3;
    w = (a >> 1) & 3;
    for (int k = 0; k < 4; k++) r[4*k +: 4] = nib(l, 4*w + k);
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.hit === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_hit", 32'd1, 32'd0);
      else                   chk("rdata", 32'(bus.rdata), 32'(exp_q.pop_front()));
    end
  end

  task automatic acc(input int a, input logic exp_hit);
    @(posedge clk); #1;
    bus.req   = 1'b1;
    bus.paddr = 21'(a >> 1);
    if (exp_hit) exp_q.push_back(exp_word(a));
    @(negedge clk);
    chk(exp_hit ? "hit" : "miss", 32'(bus.hit), 32'(exp_hit));
    @(posedge clk); #1;
    bus.req = 1'b0;
  endtask

  task automatic miss_fill(input int a, input int chg, input int inv_at, input int rst_at);
    int l;
    l = a >> 3;
    acc(a, 1'b0);
    if (chg != 0) bus.paddr = 21'(32'h1234 >> 1);
    @(negedge clk);
    chk("pull_fill", 32'(bus.pull), 32'd1);
    chk("tag_fill", 32'(bus.tag), 32'(l));
    for (int n = 0; n < 16; n++) begin
      bus.wstrobe_d  = 1'b1;
      bus.dread      = nib(l, n);
      bus.invalidate = (n == inv_at);
      if (n == rst_at) begin
        bus.req   = 1'b1;
        bus.paddr = 21'(a >> 1);
        reset     = 1'b1;
        #1;
        chk("pull_async_rst", 32'(bus.pull), 32'd0);
        chk("hit_async_rst", 32'(bus.hit), 32'd0);
        chk("tag_async_rst", 32'(bus.tag), 32'd0);
        bus.wstrobe_d = 1'b0;
        bus.req       = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.wstrobe_d  = 1'b0;
    bus.invalidate = 1'b0;
    bus.req        = 1'b1;
    bus.paddr      = 21'(a >> 1);
    @(negedge clk);
    chk("hit_done", 32'(bus.hit), 32'd0);
    chk("pull_done", 32'(bus.pull), 32'd0);
    chk("tag_done", 32'(bus.tag), 32'(l));
    @(posedge clk); #1;
    bus.req = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.req        = 1'b0;
    bus.paddr      = '0;
    bus.invalidate = 1'b0;
    bus.dread      = '0;
    bus.wstrobe_d  = 1'b0;
    #2;
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_pull", 32'(bus.pull), 32'd0);
    chk("rst_tag", 32'(bus.tag), 32'd0);
    #10;
    reset = 1'b0;

    // Basic fill and word selection.
    miss_fill(32'h10, 0, -1, -1);
    acc(32'h10, 1'b1);
    acc(32'h16, 1'b1);
    acc(32'h12, 1'b1);

    // LRU replacement in set 2.
    miss_fill(32'h30, 0, -1, -1);
    acc(32'h10, 1'b1);
    miss_fill(32'h50, 0, -1, -1);
    acc(32'h10, 1'b1);
    acc(32'h50, 1'b1);
    miss_fill(32'h30, 0, -1, -1);

    // Request changes during a fill are ignored.
    miss_fill(32'h10, 1, -1, -1);
    acc(32'h10, 1'b1);
    acc(32'h14, 1'b1);
    acc(32'h30, 1'b1);

    // Invalidate mid-fill and on the final nibble.
    miss_fill(32'h08, 0, 7, -1);
    miss_fill(32'h08, 0, -1, -1);
    acc(32'h08, 1'b1);
    miss_fill(32'h10, 0, -1, -1);
    miss_fill(32'h20, 0, 15, -1);
    miss_fill(32'h20, 0, -1, -1);
    acc(32'h22, 1'b1);

    // Asynchronous reset mid-fill.
    miss_fill(32'h40, 0, -1, 5);
    miss_fill(32'h40, 0, -1, -1);
    acc(32'h40, 1'b1);
    acc(32'h46, 1'b1);
    acc(32'h40, 1'b1);
`ifdef ICACHE_STATS_EN
    chk("miss_count", 32'(bus.miss_count), 32'd1);
    chk("hit_count", 32'(bus.hit_count), 32'd3);
`endif
    @(posedge clk); #1;
    bus.invalidate = 1'b1;
    @(posedge clk); #1;
    bus.invalidate = 1'b0;
`ifdef ICACHE_STATS_EN
    chk("miss_count_inv", 32'(bus.miss_count), 32'd0);
    chk("hit_count_inv", 32'(bus.hit_count), 32'd0);
`endif
    miss_fill(32'h40, 0, -1, -1);

    // Stray strobes outside a fill must not touch the data.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.wstrobe_d = 1'b1;
      bus.dread     = 4'(i + 9);
    end
    @(posedge clk); #1;
    bus.wstrobe_d = 1'b0;
    acc(32'h40, 1'b1);
    acc(32'h44, 1'b1);

    @(posedge clk); #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
